fifo_wr_arbiter: RTL and testbench

//   Shares the write port of the async FIFO's write-clock side among NREQ requesters.

---
 rtl/fifo_arb_pkg.sv | 21 ++
 rtl/fifo_rr_pick.sv | 46 ++++
 rtl/fifo_wr_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// ---------------------------------------------------------------------------
// fifo_arb_pkg
//   Shared types and constants for the async-FIFO write-side arbiter.
//
//   Contents:
//     arb_state_t  arbiter state (ARB_IDLE, ARB_OWN)
//     STALL_CW     width of the optional stall counter
//     STALL_MAX    saturation value of the stall counter
// ---------------------------------------------------------------------------
package fifo_arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_OWN  = 1'b1
    } arb_state_t;

    localparam int STALL_CW = 16;

    localparam logic [STALL_CW-1:0] STALL_MAX = {STALL_CW{1'b1}};

endpackage

// File: rtl/fifo_rr_pick.sv
// ---------------------------------------------------------------------------
// fifo_rr_pick
//   Combinational rotate-priority picker. It returns the first set bit of
//   mask, scanning from ptr+1 upwards and wrapping modulo NREQ. The bit at
//   ptr itself is examined last. This lets a lone requester win again when
//   it was the previous holder.
//
//   Parameters:
//     NREQ   number of mask bits (>=2)
//     OW     index width, $clog2(NREQ)
//   Ports:
//     mask   in   NREQ   candidate bits
//     ptr    in   OW     last served index (lowest priority)
//     idx    out  OW     chosen index, 0 when nothing is set
//     valid  out  1      1 when any mask bit is set
// ---------------------------------------------------------------------------
module fifo_rr_pick #(
    parameter int NREQ = 4,
    parameter int OW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] mask,
    input  logic [OW-1:0]   ptr,
    output logic [OW-1:0]   idx,
    output logic            valid
);

    // Walk the offsets 1..NREQ from ptr. The first hit wins, and later hits
    // are ignored once valid is set.
    always_comb begin
        int          cand;
        logic [OW-1:0] cand_idx;
        idx      = '0;
        valid    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand     = (int'(ptr) + k) % NREQ;
            cand_idx = OW'(cand);
            if (!valid && mask[cand_idx]) begin
                valid = 1'b1;
                idx   = cand_idx;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter
//   Shares the write port on the write-clock side of the async FIFO among
//   NREQ requesters. It uses round-robin arbitration with bursts of at most
//   MAX_BURST words. It lives entirely in the wclk domain.
//
//   winc is a combinational function of the current owner's request and the
//   registered wfull flag. Because of this, a write is never issued against a
//   stale full indication.
//
//   Optional feature (macro FIFO_ARB_STALL_CNT_EN):
//     When the macro is defined, stall_cnt counts cycles in which the owner
//     wants to write but is blocked by wfull. The count saturates at 16'hFFFF.
//     When the macro is undefined, stall_cnt is tied to zero and no counter
//     flops exist.
//
//   Parameters:
//     NREQ       number of requesters (>=2)
//     DSIZE      FIFO data width
//     MAX_BURST  max words per grant before forced re-arbitration (>=1)
//     OW         owner index width (derived)
//     BCW        beat counter width (derived)
//   Ports:
//     wclk       in   1           write-domain clock
//     wrst       in   1           asynchronous active-high reset
//     req        in   NREQ        per-requester write request, held until ack
//     req_data   in   NREQ*DSIZE  packed data, requester i at [i*DSIZE +: DSIZE]
//     ack        out  NREQ        one-hot, word of requester i accepted
//     wfull      in   1           FIFO full flag
//     winc       out  1           FIFO write enable
//     wdata      out  DSIZE       FIFO write data (0 when not busy)
//     owner      out  OW          current grant holder
//     busy       out  1           1 while in the OWN state
//     stall_cnt  out  16          owner-blocked-by-full cycle count
// ---------------------------------------------------------------------------
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int DSIZE     = 8,
    parameter int MAX_BURST = 4,
    parameter int OW        = $clog2(NREQ),
    parameter int BCW       = $clog2(MAX_BURST + 1)
) (
    input  logic                  wclk,
    input  logic                  wrst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*DSIZE-1:0] req_data,
    output logic [NREQ-1:0]       ack,
    input  logic                  wfull,
    output logic                  winc,
    output logic [DSIZE-1:0]      wdata,
    output logic [OW-1:0]         owner,
    output logic                  busy,
    output logic [STALL_CW-1:0]   stall_cnt
);

    localparam logic [BCW-1:0] BEAT_LAST = BCW'(MAX_BURST - 1);
    localparam logic [OW-1:0]  PTR_INIT  = OW'(NREQ - 1);

    arb_state_t       state;
    arb_state_t       state_nx;
    logic [OW-1:0]    owner_nx;
    logic [OW-1:0]    rr_ptr;
    logic [OW-1:0]    rr_ptr_nx;
    logic [BCW-1:0]   beat;
    logic [BCW-1:0]   beat_nx;

    logic [DSIZE-1:0] data_arr [NREQ];
    logic [NREQ-1:0]  owner_onehot;
    logic             owner_req;
    logic             release_grant;

    logic [OW-1:0]    pick_ptr;
    logic [NREQ-1:0]  pick_mask;
    logic [OW-1:0]    pick_idx;
    logic             pick_valid;

    // Unpack the flat data bus so that the owner can index it directly.
    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign data_arr[g] = req_data[g*DSIZE +: DSIZE];
    end

    assign owner_onehot = NREQ'(1) << owner;
    assign owner_req    = req[owner];

    // A single picker serves both cases. In IDLE it scans from rr_ptr. On a
    // release in OWN it scans from the current owner, which is the value
    // that rr_ptr is about to take. On a release, the owner's bit in req is
    // either already low (it dropped its request) or still high (burst
    // limit). In the burst-limit case the owner is scanned last, so it wins
    // again only if nobody else is asking. So req itself is the mask.
    assign pick_ptr  = (state == ARB_OWN) ? owner : rr_ptr;
    assign pick_mask = req;

    fifo_rr_pick #(
        .NREQ (NREQ),
        .OW   (OW)
    ) u_pick (
        .mask  (pick_mask),
        .ptr   (pick_ptr),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    // State register. Reset forces IDLE immediately. Any partial burst is
    // dropped and is not resumed.
    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            state  <= ARB_IDLE;
            owner  <= '0;
            rr_ptr <= PTR_INIT;
            beat   <= '0;
        end else begin
            state  <= state_nx;
            owner  <= owner_nx;
            rr_ptr <= rr_ptr_nx;
            beat   <= beat_nx;
        end
    end

    // Release happens when the owner withdraws its request (even while
    // stalled on full) or when it lands its last permitted beat.
    assign release_grant = busy & (~owner_req | (winc & (beat == BEAT_LAST)));

    // Next-state logic. A release chains straight into the next owner in the
    // same cycle, so a handover costs no idle cycle.
    always_comb begin
        state_nx  = state;
        owner_nx  = owner;
        rr_ptr_nx = rr_ptr;
        beat_nx   = beat;
        case (state)
            ARB_IDLE: begin
                if (pick_valid) begin
                    state_nx = ARB_OWN;
                    owner_nx = pick_idx;
                    beat_nx  = '0;
                end
            end
            ARB_OWN: begin
                if (release_grant) begin
                    rr_ptr_nx = owner;
                    beat_nx   = '0;
                    if (pick_valid) begin
                        owner_nx = pick_idx;
                    end else begin
                        state_nx = ARB_IDLE;
                    end
                end else if (winc) begin
                    beat_nx = beat + BCW'(1);
                end
            end
            default: begin
                state_nx = ARB_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the current state and live inputs. wfull is
    // already registered upstream, so gating winc with it combinationally is
    // safe.
    always_comb begin
        busy  = (state == ARB_OWN);
        winc  = busy & owner_req & ~wfull;
        ack   = winc ? owner_onehot : '0;
        wdata = busy ? data_arr[owner] : '0;
    end

`ifdef FIFO_ARB_STALL_CNT_EN
    logic [STALL_CW-1:0] stall_q;

    // Count owner-blocked cycles. The counter saturates instead of wrapping,
    // so a long stall never looks short.
    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            stall_q <= '0;
        end else if (busy && owner_req && wfull && (stall_q != STALL_MAX)) begin
            stall_q <= stall_q + STALL_CW'(1);
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

`ifndef SYNTHESIS
    a_ack_onehot : assert property (@(posedge wclk) disable iff (wrst) $onehot0(ack));
    a_no_full_write : assert property (@(posedge wclk) disable iff (wrst) winc |-> !wfull);
    a_beat_bound : assert property (@(posedge wclk) disable iff (wrst) beat <= BEAT_LAST);
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fifo_wr_arbiter
//   Directed bench for fifo_wr_arbiter (NREQ=4, DSIZE=8, MAX_BURST=4).
//   Inputs change 1 time unit after the rising edge. Outputs are compared
//   3 time units after the rising edge. Expected stall_cnt depends on
//   FIFO_ARB_STALL_CNT_EN.
// ---------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

    logic        wclk = 1'b0;
    logic        wrst = 1'b1;
    logic [3:0]  req = '0;
    logic [31:0] req_data = '0;
    logic        wfull_drv = 1'b0;
    logic        wfull;
    logic [3:0]  ack;
    logic        winc;
    logic [7:0]  wdata;
    logic [1:0]  owner;
    logic        busy;
    logic [15:0] stall_cnt;

    int vectors = 0;
    int miscompares = 0;

    // Small FIFO model, used only by the fill test. Its full flag is derived
    // from a registered count, matching the real write-pointer logic.
    logic use_model = 1'b0;
    logic model_clr = 1'b0;
    int   fifo_cnt = 0;
    int   write_cnt = 0;
    int   ack_cnt = 0;
    int   overflow_cnt = 0;
    logic model_full;

    localparam logic [31:0] DATA_A  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    localparam logic [31:0] DATA_ID = {8'd3, 8'd2, 8'd1, 8'd0};

`ifdef FIFO_ARB_STALL_CNT_EN
    localparam logic [15:0] EXP_STALL = 16'd3;
`else
    localparam logic [15:0] EXP_STALL = 16'd0;
`endif

    assign model_full = (fifo_cnt == 16);
    assign wfull = use_model ? model_full : wfull_drv;

    always #5 wclk = ~wclk;

    fifo_wr_arbiter #(
        .NREQ      (4),
        .DSIZE     (8),
        .MAX_BURST (4)
    ) dut (
        .wclk      (wclk),
        .wrst      (wrst),
        .req       (req),
        .req_data  (req_data),
        .ack       (ack),
        .wfull     (wfull),
        .winc      (winc),
        .wdata     (wdata),
        .owner     (owner),
        .busy      (busy),
        .stall_cnt (stall_cnt)
    );

    // Model FIFO bookkeeping: accepted writes, ack pulses, overflow attempts.
    always @(posedge wclk) begin
        if (model_clr) begin
            fifo_cnt     <= 0;
            write_cnt    <= 0;
            ack_cnt      <= 0;
            overflow_cnt <= 0;
        end else if (use_model) begin
            if (winc) begin
                write_cnt <= write_cnt + 1;
                if (fifo_cnt >= 16) overflow_cnt <= overflow_cnt + 1;
                else                fifo_cnt     <= fifo_cnt + 1;
            end
            if (|ack) ack_cnt <= ack_cnt + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] r, input logic wf);
        req       = r;
        wfull_drv = wf;
        #2;
    endtask

    task automatic nextCycle;
        @(posedge wclk);
        #1;
    endtask

    task automatic checkWrite(input string tag, input logic [3:0] exp_ack,
                              input logic [1:0] exp_owner, input logic [7:0] exp_data);
        checkOutput({tag, " winc"},  winc,  1'b1);
        checkOutput({tag, " ack"},   ack,   exp_ack);
        checkOutput({tag, " owner"}, owner, exp_owner);
        checkOutput({tag, " wdata"}, wdata, exp_data);
    endtask

    task automatic doReset;
        wrst = 1'b1;
        nextCycle();
        wrst = 1'b0;
        applyStimulus(4'b0000, 1'b0);
    endtask

    initial begin
        $display("[TB] start");
        req_data = DATA_A;
        repeat (3) @(posedge wclk);
        #1;
        wrst = 1'b0;
        applyStimulus(4'b0000, 1'b0);
        checkOutput("rst winc",  winc,      1'b0);
        checkOutput("rst ack",   ack,       4'b0000);
        checkOutput("rst busy",  busy,      1'b0);
        checkOutput("rst owner", owner,     2'd0);
        checkOutput("rst wdata", wdata,     8'h00);
        checkOutput("rst stall", stall_cnt, 16'd0);

        // Single requester 2 streams across three burst boundaries.
        nextCycle();
        applyStimulus(4'b0100, 1'b0);
        checkOutput("t2 arb winc", winc, 1'b0);
        checkOutput("t2 arb busy", busy, 1'b0);
        for (int i = 0; i < 12; i++) begin
            nextCycle();
            applyStimulus(4'b0100, 1'b0);
            checkWrite($sformatf("t2 beat%0d", i), 4'b0100, 2'd2, 8'hA2);
        end

        // Asynchronous reset in the middle of a burst.
        nextCycle();
        wrst = 1'b1;
        #1;
        checkOutput("t1 winc",  winc,      1'b0);
        checkOutput("t1 ack",   ack,       4'b0000);
        checkOutput("t1 busy",  busy,      1'b0);
        checkOutput("t1 owner", owner,     2'd0);
        checkOutput("t1 wdata", wdata,     8'h00);
        checkOutput("t1 stall", stall_cnt, 16'd0);
        nextCycle();
        wrst = 1'b0;
        applyStimulus(4'b0000, 1'b0);

        // All four requesters: four-word bursts in order 0,1,2,3.
        req_data = DATA_ID;
        nextCycle();
        applyStimulus(4'b1111, 1'b0);
        checkOutput("t3 arb winc", winc, 1'b0);
        for (int i = 0; i < 16; i++) begin
            nextCycle();
            applyStimulus(4'b1111, 1'b0);
            checkWrite($sformatf("t3 w%0d", i), 4'(1 << (i / 4)), 2'(i / 4), 8'(i / 4));
        end
        nextCycle();
        applyStimulus(4'b0000, 1'b0);
        checkOutput("t3 drop winc", winc, 1'b0);
        nextCycle();
        applyStimulus(4'b0000, 1'b0);
        checkOutput("t3 idle busy", busy, 1'b0);

        // Owner 0 drops after one beat; requester 3 takes over with no idle cycle.
        req_data = DATA_A;
        doReset();
        nextCycle();
        applyStimulus(4'b1001, 1'b0);
        checkOutput("t5 arb winc", winc, 1'b0);
        nextCycle();
        applyStimulus(4'b1001, 1'b0);
        checkWrite("t5 own0", 4'b0001, 2'd0, 8'hA0);
        nextCycle();
        applyStimulus(4'b1000, 1'b0);
        checkOutput("t5 drop winc", winc, 1'b0);
        nextCycle();
        applyStimulus(4'b1000, 1'b0);
        checkWrite("t5 own3", 4'b1000, 2'd3, 8'hA3);
        nextCycle();
        applyStimulus(4'b0000, 1'b0);
        checkOutput("t5 end winc", winc, 1'b0);

        // Owner 1: two beats, stalled three cycles by full, then two more beats.
        nextCycle();
        applyStimulus(4'b0010, 1'b0);
        checkOutput("t4 arb busy", busy, 1'b0);
        for (int i = 0; i < 2; i++) begin
            nextCycle();
            applyStimulus(4'b0010, 1'b0);
            checkWrite($sformatf("t4 pre%0d", i), 4'b0010, 2'd1, 8'hA1);
        end
        for (int i = 0; i < 3; i++) begin
            nextCycle();
            applyStimulus(4'b0010, 1'b1);
            checkOutput($sformatf("t4 stall%0d winc", i),  winc,  1'b0);
            checkOutput($sformatf("t4 stall%0d ack", i),   ack,   4'b0000);
            checkOutput($sformatf("t4 stall%0d owner", i), owner, 2'd1);
            checkOutput($sformatf("t4 stall%0d busy", i),  busy,  1'b1);
        end
        for (int i = 0; i < 2; i++) begin
            nextCycle();
            applyStimulus(4'b0010, 1'b0);
            checkWrite($sformatf("t4 post%0d", i), 4'b0010, 2'd1, 8'hA1);
        end
        checkOutput("t4 stall_cnt", stall_cnt, EXP_STALL);
        nextCycle();
        applyStimulus(4'b0010, 1'b0);
        checkWrite("t4 rewin", 4'b0010, 2'd1, 8'hA1);
        nextCycle();
        applyStimulus(4'b0000, 1'b0);
        checkOutput("t4 end winc", winc, 1'b0);

        // Fill a 16-deep model FIFO from two requesters and hold against full.
        doReset();
        model_clr = 1'b1;
        nextCycle();
        model_clr = 1'b0;
        use_model = 1'b1;
        applyStimulus(4'b0011, 1'b0);
        checkOutput("t6 arb winc", winc, 1'b0);
        for (int i = 0; i < 30; i++) begin
            nextCycle();
            applyStimulus(4'b0011, 1'b0);
            checkOutput($sformatf("t6 c%0d winc", i), winc, (i < 16) ? 1'b1 : 1'b0);
        end
        nextCycle();
        applyStimulus(4'b0000, 1'b0);
        checkOutput("t6 writes",   write_cnt,    32'd16);
        checkOutput("t6 acks",     ack_cnt,      32'd16);
        checkOutput("t6 overflow", overflow_cnt, 32'd0);
        checkOutput("t6 depth",    fifo_cnt,     32'd16);
        use_model = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
